rf_operand_sequencer: RTL and testbench
=======================================

# rf_operand_sequencer

Control stage directly upstream of the 32x32 register file. It accepts one decoded-format instruction word at a time and drives the register file read ports to fetch the source operands. It hands the operands and decoded fields to the ALU through a valid/ready handshake, waits for the ALU result, then drives the register file write port for writeback. It is the only block in the datapath that toggles the register file READ/WRITE strobes.

## Interface
- DATA_WIDTH, 32, operand/result width
- ADDR_WIDTH, 5, register index width

- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- INSTR  in  32  instruction word; opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0]
- INSTR_VALID  in  1  INSTR is valid
- INSTR_READY  out  1  block can accept INSTR
- RF_ADDR_R1, RF_ADDR_R2  out  ADDR_WIDTH  register file read addresses (rs, rt)
- RF_READ  out  1  register file read strobe
- RF_DATA_R1, RF_DATA_R2  in  DATA_WIDTH  register file read data
- RF_ADDR_W  out  ADDR_WIDTH  write address
- RF_DATA_W  out  DATA_WIDTH  write data
- RF_WRITE  out  1  register file write strobe
- OP_A, OP_B  out  DATA_WIDTH  latched operands (rs data, rt data)
- IMM  out  DATA_WIDTH  sign-extended imm
- OPCODE, FUNCT  out  6  latched fields; SHAMT out 5
- OPND_VALID  out  1  operands/fields valid to ALU
- OPND_READY  in  1  ALU accepts operands
- RESULT  in  DATA_WIDTH  ALU result
- RESULT_VALID  in  1  RESULT valid (single-cycle pulse or level)
- BUSY  out  1  high in every state except IDLE

## Operation
- All outputs are registered (Moore). States: IDLE, RD, CAP, ISSUE, WAIT, WB.
- IDLE: INSTR_READY=1. On INSTR_VALID&INSTR_READY, latch INSTR and go to RD.
- RD: RF_READ=1, RF_ADDR_R1=rs, RF_ADDR_R2=rt. Go to CAP.
- CAP: RF_READ held 1, addresses held. At the end of the cycle, latch RF_DATA_R1 into OP_A and RF_DATA_R2 into OP_B. Go to ISSUE.
- ISSUE: OPND_VALID=1. OP_A, OP_B, IMM, OPCODE, FUNCT and SHAMT are stable until OPND_READY is sampled high, then go to WAIT.
- WAIT: on RESULT_VALID, latch RESULT.
  - If the instruction writes back and the destination is nonzero, go to WB.
  - Otherwise go to IDLE.
- WB: RF_WRITE=1, RF_ADDR_W=dest, RF_DATA_W=latched RESULT, for exactly one cycle. Go to IDLE.
- Destination: opcode 0 (R-type) uses rd; all other opcodes use rt.
- No writeback for opcode 0x2B (store), 0x04/0x05 (branch), or dest==0.
- IMM = {{16{imm[15]}}, imm[15:0]}.
- RF_READ, RF_WRITE and OPND_VALID are never high at the same time.
- INSTR_VALID outside IDLE is ignored. INSTR is not consumed until INSTR_READY is high.

## Timing
- Reset: state IDLE. INSTR_READY=1 (from the cycle after RST is sampled). All other outputs 0, including BUSY, strobes, addresses, OP_A/OP_B, IMM and fields.
- RST takes effect at the edge where it is sampled high, from any state. The operation in progress is aborted and no later strobe is issued. A WB cycle already being driven when RST is sampled completes that cycle.
- Accept at edge 0 gives:
  - RD in cycle 1, CAP in cycle 2
  - OPND_VALID in cycle 3
  - WAIT from cycle 4 if OPND_READY is high in cycle 3
- With RESULT_VALID sampled in cycle k: WB in cycle k+1, IDLE (INSTR_READY=1) in cycle k+2. Best-case initiation interval is 6 cycles.
- Back-to-back: an instruction presented in the first IDLE cycle after WB is accepted in that cycle.
- RESULT_VALID during ISSUE is ignored. OPND_READY outside ISSUE is ignored.

## Test plan
- Reset: hold RST=1 for 2 cycles -> all outputs 0 except INSTR_READY=1; BUSY=0.
- R-type 0x00414020 with RF r2=0x5, r1=0x7 -> RF_READ high for 2 cycles, ADDR_R1=2, ADDR_R2=1; OPND_VALID in cycle 3 with OP_A=5, OP_B=7, FUNCT=0x20. RESULT=0xC -> one-cycle RF_WRITE with ADDR_W=8, DATA_W=0x0000000C.
- I-type 0x2022FFFF -> IMM=0xFFFFFFFF, OPCODE=0x08. RESULT=0x1234 -> write to ADDR_W=2.
- No writeback: store 0xAC220004 and R-type 0x00410020 (rd=0) -> RF_WRITE stays 0; IDLE one cycle after RESULT_VALID.
- Stalls: hold OPND_READY=0 for 5 cycles -> OPND_VALID and operands stable throughout. Delay RESULT_VALID 10 cycles -> no RF_WRITE until the cycle after it. INSTR_VALID pulses during BUSY are ignored.
- Reset mid-operation: assert RST in ISSUE and separately in WAIT -> outputs return to reset values next cycle, no RF_WRITE; a fresh instruction then completes normally.

Source files
------------

// File: rtl/rf_operand_sequencer.sv
// Register-file operand sequencer: reads rs/rt, issues operands and decoded fields
// to the ALU over valid/ready, then writes the ALU result back to rd or rt.
module rf_operand_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [31:0]           INSTR,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic                  RF_READ,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  output logic                  RF_WRITE,
  output logic [DATA_WIDTH-1:0] OP_A,
  output logic [DATA_WIDTH-1:0] OP_B,
  output logic [DATA_WIDTH-1:0] IMM,
  output logic [5:0]            OPCODE,
  output logic [5:0]            FUNCT,
  output logic [4:0]            SHAMT,
  output logic                  OPND_VALID,
  input  logic                  OPND_READY,
  input  logic [DATA_WIDTH-1:0] RESULT,
  input  logic                  RESULT_VALID,
  output logic                  BUSY
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_CAP, S_ISSUE, S_WAIT, S_WB
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] dest_q;
  logic                  wb_q;

  logic [5:0]  f_opcode;
  logic [4:0]  f_rs;
  logic [4:0]  f_rt;
  logic [4:0]  f_rd;
  logic [4:0]  f_shamt;
  logic [5:0]  f_funct;
  logic signed [15:0] f_imm;

  assign f_opcode = INSTR[31:26];
  assign f_rs     = INSTR[25:21];
  assign f_rt     = INSTR[20:16];
  assign f_rd     = INSTR[15:11];
  assign f_shamt  = INSTR[10:6];
  assign f_funct  = INSTR[5:0];
  assign f_imm    = INSTR[15:0];

  function automatic logic [4:0] dest_of(input logic [5:0] opc, input logic [4:0] rt,
                                         input logic [4:0] rd);
    return (opc == OP_RTYPE) ? rd : rt;
  endfunction

  // Stores and branches never write; writes to r0 are dropped here rather than in the RF.
  function automatic logic writes_back(input logic [5:0] opc, input logic [4:0] dest);
    return !(opc == OP_SW || opc == OP_BEQ || opc == OP_BNE) && (dest != 5'd0);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sext_imm(input logic signed [15:0] imm);
    return DATA_WIDTH'(imm);
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      INSTR_READY <= 1'b1;
      BUSY        <= 1'b0;
      RF_READ     <= 1'b0;
      RF_WRITE    <= 1'b0;
      OPND_VALID  <= 1'b0;
      RF_ADDR_R1  <= '0;
      RF_ADDR_R2  <= '0;
      RF_ADDR_W   <= '0;
      RF_DATA_W   <= '0;
      OP_A        <= '0;
      OP_B        <= '0;
      IMM         <= '0;
      OPCODE      <= '0;
      FUNCT       <= '0;
      SHAMT       <= '0;
      dest_q      <= '0;
      wb_q        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (INSTR_VALID && INSTR_READY) begin
            INSTR_READY <= 1'b0;
            BUSY        <= 1'b1;
            RF_READ     <= 1'b1;
            RF_ADDR_R1  <= ADDR_WIDTH'(f_rs);
            RF_ADDR_R2  <= ADDR_WIDTH'(f_rt);
            OPCODE      <= f_opcode;
            FUNCT       <= f_funct;
            SHAMT       <= f_shamt;
            IMM         <= sext_imm(f_imm);
            dest_q      <= ADDR_WIDTH'(dest_of(f_opcode, f_rt, f_rd));
            wb_q        <= writes_back(f_opcode, dest_of(f_opcode, f_rt, f_rd));
            state       <= S_RD;
          end
        end
        S_RD: state <= S_CAP;
        // Read data is taken at the end of the second read-strobe cycle.
        S_CAP: begin
          OP_A       <= RF_DATA_R1;
          OP_B       <= RF_DATA_R2;
          RF_READ    <= 1'b0;
          OPND_VALID <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          if (OPND_READY) begin
            OPND_VALID <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (RESULT_VALID) begin
            if (wb_q) begin
              RF_WRITE  <= 1'b1;
              RF_ADDR_W <= dest_q;
              RF_DATA_W <= RESULT;
              state     <= S_WB;
            end else begin
              INSTR_READY <= 1'b1;
              BUSY        <= 1'b0;
              state       <= S_IDLE;
            end
          end
        end
        S_WB: begin
          RF_WRITE    <= 1'b0;
          INSTR_READY <= 1'b1;
          BUSY        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_operand_sequencer.sv
// Directed bench for rf_operand_sequencer: fixed-content register file stub and
// a scripted ALU; inputs change and outputs are sampled on the falling edge.
module tb_rf_operand_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
  logic        RF_READ, RF_WRITE;
  logic [31:0] RF_DATA_R1, RF_DATA_R2, RF_DATA_W;
  logic [31:0] OP_A, OP_B, IMM, RESULT;
  logic [5:0]  OPCODE, FUNCT;
  logic [4:0]  SHAMT;
  logic        OPND_VALID, OPND_READY, RESULT_VALID, BUSY;

  logic [31:0] rf [32];
  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  assign RF_DATA_R1 = rf[RF_ADDR_R1];
  assign RF_DATA_R2 = rf[RF_ADDR_R2];

  rf_operand_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .CLK(CLK), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2),
    .RF_READ(RF_READ), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2),
    .RF_ADDR_W(RF_ADDR_W), .RF_DATA_W(RF_DATA_W), .RF_WRITE(RF_WRITE),
    .OP_A(OP_A), .OP_B(OP_B), .IMM(IMM), .OPCODE(OPCODE), .FUNCT(FUNCT),
    .SHAMT(SHAMT), .OPND_VALID(OPND_VALID), .OPND_READY(OPND_READY),
    .RESULT(RESULT), .RESULT_VALID(RESULT_VALID), .BUSY(BUSY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string ctx);
    check({ctx, " instr_ready"}, 32'(INSTR_READY), 32'd1);
    check({ctx, " busy"},        32'(BUSY),        32'd0);
    check({ctx, " rf_read"},     32'(RF_READ),     32'd0);
    check({ctx, " rf_write"},    32'(RF_WRITE),    32'd0);
    check({ctx, " opnd_valid"},  32'(OPND_VALID),  32'd0);
    check({ctx, " addr_r1"},     32'(RF_ADDR_R1),  32'd0);
    check({ctx, " addr_r2"},     32'(RF_ADDR_R2),  32'd0);
    check({ctx, " addr_w"},      32'(RF_ADDR_W),   32'd0);
    check({ctx, " data_w"},      RF_DATA_W,        32'd0);
    check({ctx, " op_a"},        OP_A,             32'd0);
    check({ctx, " op_b"},        OP_B,             32'd0);
    check({ctx, " imm"},         IMM,              32'd0);
    check({ctx, " opcode"},      32'(OPCODE),      32'd0);
    check({ctx, " funct"},       32'(FUNCT),       32'd0);
    check({ctx, " shamt"},       32'(SHAMT),       32'd0);
  endtask

  // Called on a falling edge with the DUT idle; returns on the falling edge of
  // the first idle cycle afterwards.
  task automatic run_instr(input string name, input logic [31:0] instr,
                           input logic [31:0] exp_a, input logic [31:0] exp_b,
                           input logic [31:0] exp_imm, input logic [31:0] result,
                           input logic exp_wr, input logic [4:0] exp_waddr,
                           input int ready_delay, input int result_delay,
                           input logic noise);
    check({name, " idle ready"}, 32'(INSTR_READY), 32'd1);
    INSTR = instr; INSTR_VALID = 1'b1;
    tick;
    INSTR_VALID = noise; INSTR = 32'hFFFF_FFFF;
    check({name, " rd rf_read"}, 32'(RF_READ), 32'd1);
    check({name, " rd addr_r1"}, 32'(RF_ADDR_R1), 32'(instr[25:21]));
    check({name, " rd addr_r2"}, 32'(RF_ADDR_R2), 32'(instr[20:16]));
    check({name, " rd busy"}, 32'(BUSY), 32'd1);
    check({name, " rd ready"}, 32'(INSTR_READY), 32'd0);
    tick;
    check({name, " cap rf_read"}, 32'(RF_READ), 32'd1);
    check({name, " cap opnd_valid"}, 32'(OPND_VALID), 32'd0);
    tick;
    check({name, " issue opnd_valid"}, 32'(OPND_VALID), 32'd1);
    check({name, " issue rf_read"}, 32'(RF_READ), 32'd0);
    check({name, " issue op_a"}, OP_A, exp_a);
    check({name, " issue op_b"}, OP_B, exp_b);
    check({name, " issue imm"}, IMM, exp_imm);
    check({name, " issue opcode"}, 32'(OPCODE), 32'(instr[31:26]));
    check({name, " issue funct"}, 32'(FUNCT), 32'(instr[5:0]));
    check({name, " issue shamt"}, 32'(SHAMT), 32'(instr[10:6]));
    for (int i = 0; i < ready_delay; i++) begin
      RESULT = 32'hDEAD_BEEF; RESULT_VALID = noise;
      tick;
      check({name, " stall opnd_valid"}, 32'(OPND_VALID), 32'd1);
      check({name, " stall op_a"}, OP_A, exp_a);
      check({name, " stall op_b"}, OP_B, exp_b);
      check({name, " stall imm"}, IMM, exp_imm);
    end
    RESULT_VALID = 1'b0; OPND_READY = 1'b1;
    tick;
    OPND_READY = noise;
    check({name, " wait opnd_valid"}, 32'(OPND_VALID), 32'd0);
    check({name, " wait busy"}, 32'(BUSY), 32'd1);
    for (int i = 0; i < result_delay; i++) begin
      tick;
      check({name, " wait rf_write"}, 32'(RF_WRITE), 32'd0);
      check({name, " wait ready"}, 32'(INSTR_READY), 32'd0);
    end
    INSTR_VALID = 1'b0; OPND_READY = 1'b0;
    RESULT = result; RESULT_VALID = 1'b1;
    tick;
    RESULT_VALID = 1'b0;
    if (exp_wr) begin
      check({name, " wb rf_write"}, 32'(RF_WRITE), 32'd1);
      check({name, " wb addr_w"}, 32'(RF_ADDR_W), 32'(exp_waddr));
      check({name, " wb data_w"}, RF_DATA_W, result);
      check({name, " wb ready"}, 32'(INSTR_READY), 32'd0);
      check({name, " wb excl"}, 32'(RF_READ | OPND_VALID), 32'd0);
      tick;
    end
    check({name, " end rf_write"}, 32'(RF_WRITE), 32'd0);
    check({name, " end ready"}, 32'(INSTR_READY), 32'd1);
    check({name, " end busy"}, 32'(BUSY), 32'd0);
  endtask

  // Start an instruction, stop in ISSUE (or WAIT), reset, and check the abort.
  task automatic reset_mid(input string name, input logic [31:0] instr, input logic to_wait);
    INSTR = instr; INSTR_VALID = 1'b1;
    tick;
    INSTR_VALID = 1'b0;
    tick;
    tick;
    check({name, " pre opnd_valid"}, 32'(OPND_VALID), 32'd1);
    if (to_wait) begin
      OPND_READY = 1'b1;
      tick;
      OPND_READY = 1'b0;
      check({name, " pre wait"}, 32'(OPND_VALID), 32'd0);
    end
    RST = 1'b1; RESULT = 32'h0000_0055; RESULT_VALID = 1'b1;
    tick;
    RST = 1'b0;
    check_reset_outputs(name);
    tick;
    RESULT_VALID = 1'b0;
    check({name, " post rf_write"}, 32'(RF_WRITE), 32'd0);
    check({name, " post busy"}, 32'(BUSY), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
    rf[0] = 32'd0; rf[1] = 32'h7; rf[2] = 32'h5;
    RST = 1'b1; INSTR = '0; INSTR_VALID = 1'b0; OPND_READY = 1'b0;
    RESULT = '0; RESULT_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    tick;
    check_reset_outputs("reset");
    RST = 1'b0;
    tick;
    check_reset_outputs("reset idle");

    //        name      instr          op_a  op_b  imm            result        wr    waddr rdy res noise
    run_instr("add",    32'h0041_4020, 32'h5, 32'h7, 32'h0000_4020, 32'h0000_000C, 1'b1, 5'd8, 0, 0, 1'b0);
    run_instr("addi",   32'h2022_FFFF, 32'h7, 32'h5, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 5'd2, 0, 0, 1'b0);
    run_instr("stall",  32'h2022_FFFF, 32'h7, 32'h5, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 5'd2, 5, 10, 1'b1);
    run_instr("sw",     32'hAC22_0004, 32'h7, 32'h5, 32'h0000_0004, 32'h0000_0099, 1'b0, 5'd0, 0, 0, 1'b0);
    run_instr("rd0",    32'h0041_0020, 32'h5, 32'h7, 32'h0000_0020, 32'h0000_000C, 1'b0, 5'd0, 0, 0, 1'b0);
    run_instr("beq",    32'h1022_0003, 32'h7, 32'h5, 32'h0000_0003, 32'h0000_0001, 1'b0, 5'd0, 1, 2, 1'b1);
    run_instr("bne",    32'h1422_0001, 32'h7, 32'h5, 32'h0000_0001, 32'h0000_0001, 1'b0, 5'd0, 0, 0, 1'b0);
    run_instr("addirt0",32'h2020_0005, 32'h7, 32'h0,  32'h0000_0005, 32'h0000_000C, 1'b0, 5'd0, 0, 0, 1'b0);
    run_instr("sll",    32'h0002_1940, 32'h0, 32'h5, 32'h0000_1940, 32'h0000_00A0, 1'b1, 5'd3, 0, 1, 1'b0);

    reset_mid("rst_issue", 32'h0041_4020, 1'b0);
    run_instr("after_rst_issue", 32'h0041_4020, 32'h5, 32'h7, 32'h0000_4020, 32'h0000_000C, 1'b1, 5'd8, 0, 0, 1'b0);
    reset_mid("rst_wait", 32'h2022_FFFF, 1'b1);
    run_instr("after_rst_wait", 32'h2022_FFFF, 32'h7, 32'h5, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 5'd2, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
